// File: rtl/adc_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_capture_pkg
// Description : Shared types and constants for the AD9361 capture controller.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_capture_pkg;

    typedef enum logic [2:0] {
        RESET_WAIT = 3'd0,
        PRESET     = 3'd1,
        ARMED      = 3'd2,
        CAPTURE    = 3'd3,
        DRAIN      = 3'd4
    } state_t;

    localparam int BEAT_BYTES = 8;
    localparam int SAMPLE_W   = 16;

    // Address field is sized for the widest supported ADDR_WIDTH (32).
    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } cmd_t;

endpackage
`default_nettype wire

// File: rtl/adc_capture_fifo.sv
`default_nettype none
// ============================================================================
// Module      : adc_capture_fifo
// Description : Synchronous first-word-fall-through FIFO with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_capture_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full     = (r_count == CW'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];
    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/adc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adc_capture_ctrl
// Description : AD9361 bring-up sequencer and I0/Q0 capture into a circular
//               DDR3 buffer via fixed-length burst commands.
//               Optional macro ADC_CAPTURE_PATTERN_EN replaces sample data
//               with a counting test pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int ADDR_WIDTH    = 30,
    parameter int BASE_ADDR     = 0,
    parameter int BUF_BYTES     = 262144,
    parameter int BURST_BEATS   = 16,
    parameter int FIFO_DEPTH    = 64,
    parameter int PRESET_CYCLES = 16
) (
    input  logic                  adc_clk,
    input  logic                  adc_rst,
    input  logic                  calib_done,
    input  logic                  cfg_start,
    input  logic                  cfg_stop,
    input  logic [31:0]           cfg_num_bursts,
    output logic                  adc_core_preset,
    output logic                  adc_enable_i0,
    output logic                  adc_enable_q0,
    output logic                  adc_r1_mode,
    input  logic                  adc_valid,
    input  logic [15:0]           adc_data_i0,
    input  logic [15:0]           adc_data_q0,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [7:0]            cmd_len,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [63:0]           wr_data,
    output logic                  wr_last,
    output logic                  status_busy,
    output logic                  status_overflow,
    output logic [31:0]           status_bursts
);

    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int AW1 = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]         c_BURST       = CW'(BURST_BEATS);
    localparam logic [ADDR_WIDTH-1:0] c_BASE        = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [AW1-1:0]        c_END         = AW1'(BASE_ADDR) + AW1'(BUF_BYTES);
    localparam logic [15:0]           c_PRESET_LAST = 16'(PRESET_CYCLES - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [15:0]           r_preset_cnt;
    logic                  r_preset;
    logic                  r_enable;
    logic                  r_r1;
    logic                  r_half_valid;
    logic [31:0]           r_half;
    logic [31:0]           w_sample;
    logic                  w_push_try;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [CW-1:0]         w_fifo_count;
    logic [63:0]           w_fifo_data;
    logic                  r_cmd_valid;
    cmd_t                  r_cmd;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [8:0]            r_beats_left;
    logic [31:0]           r_cmd_count;
    logic [31:0]           r_bursts;
    logic                  r_overflow;
    logic                  w_cmd_hs;
    logic                  w_wr_valid;
    logic                  w_wr_last;
    logic                  w_beat_hs;
    logic                  w_issue;
    logic [CW-1:0]         w_issue_beats;
    logic                  w_start;
    logic                  w_quota_hit;
    logic                  w_prebring;
    logic [11:0]           w_burst_bytes;
    logic [AW1-1:0]        w_ptr_sum;

    assign w_start     = (r_state == ARMED) && cfg_start;
    assign w_cmd_hs    = r_cmd_valid && cmd_ready;
    assign w_wr_valid  = !w_fifo_empty && (r_beats_left != 9'd0);
    assign w_wr_last   = w_wr_valid && (r_beats_left == 9'd1);
    assign w_beat_hs   = w_wr_valid && wr_ready;
    assign w_push_try  = (r_state == CAPTURE) && adc_valid && r_half_valid;
    assign w_quota_hit = (cfg_num_bursts != 32'd0) &&
                         ((r_cmd_count + 32'(w_cmd_hs)) >= cfg_num_bursts);
    assign w_prebring  = (r_state == RESET_WAIT) || (r_state == PRESET);

    // A new burst is only considered once the previous one is fully written.
    assign w_issue_beats = (w_fifo_count >= c_BURST) ? c_BURST : w_fifo_count;
    assign w_issue = calib_done && !r_cmd_valid && (r_beats_left == 9'd0) &&
                     (((r_state == CAPTURE) && (w_fifo_count >= c_BURST)) ||
                      ((r_state == DRAIN) && (w_fifo_count != '0)));

    assign w_burst_bytes = (12'(r_cmd.len) + 12'd1) << 3;
    assign w_ptr_sum     = AW1'(r_ptr) + AW1'(w_burst_bytes);

`ifdef ADC_CAPTURE_PATTERN_EN
    logic [15:0] r_pat_cnt;
    logic        w_unused_data;

    assign w_sample      = {r_pat_cnt, ~r_pat_cnt};
    assign w_unused_data = ^{adc_data_i0, adc_data_q0};

    always_ff @(posedge adc_clk) begin
        if (adc_rst || w_start)                   r_pat_cnt <= '0;
        else if ((r_state == CAPTURE) && adc_valid) r_pat_cnt <= r_pat_cnt + 16'd1;
    end
`else
    assign w_sample = {adc_data_q0, adc_data_i0};
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RESET_WAIT: if (calib_done) w_state_next = PRESET;
            PRESET:     if (r_preset_cnt == c_PRESET_LAST) w_state_next = ARMED;
            ARMED:      if (cfg_start) w_state_next = CAPTURE;
            CAPTURE:    if (cfg_stop || w_quota_hit) w_state_next = DRAIN;
            DRAIN:      if (w_fifo_empty && (r_beats_left == 9'd0) && !r_cmd_valid)
                            w_state_next = ARMED;
            default:    w_state_next = RESET_WAIT;
        endcase
        if (!calib_done) w_state_next = RESET_WAIT;
    end

    always_ff @(posedge adc_clk) begin
        if (adc_rst) r_state <= RESET_WAIT;
        else         r_state <= w_state_next;
    end

    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            r_preset_cnt <= '0;
            r_preset     <= 1'b1;
            r_enable     <= 1'b0;
            r_r1         <= 1'b0;
            r_half_valid <= 1'b0;
            r_half       <= '0;
            r_cmd_valid  <= 1'b0;
            r_cmd        <= '0;
            r_ptr        <= c_BASE;
            r_beats_left <= '0;
            r_cmd_count  <= '0;
            r_bursts     <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_preset_cnt <= (r_state == PRESET) ? r_preset_cnt + 16'd1 : 16'd0;
            // ADC controls follow the state one cycle late; calib loss acts at once.
            r_preset <= !calib_done || w_prebring;
            r_enable <= calib_done && !w_prebring;
            r_r1     <= calib_done && !w_prebring;

            if (r_state != CAPTURE) begin
                r_half_valid <= 1'b0;
            end else if (adc_valid) begin
                r_half_valid <= !r_half_valid;
                if (!r_half_valid) r_half <= w_sample;
            end

            if (!calib_done) begin
                r_cmd_valid  <= 1'b0;
                r_beats_left <= '0;
            end else if (w_issue) begin
                r_cmd_valid <= 1'b1;
                r_cmd.addr  <= 32'(r_ptr);
                r_cmd.len   <= 8'(w_issue_beats - CW'(1));
            end else if (w_cmd_hs) begin
                r_cmd_valid  <= 1'b0;
                r_beats_left <= 9'(r_cmd.len) + 9'd1;
            end else if (w_beat_hs) begin
                r_beats_left <= r_beats_left - 9'd1;
            end

            if (w_start)       r_ptr <= c_BASE;
            else if (w_cmd_hs) r_ptr <= (w_ptr_sum >= c_END) ? c_BASE : w_ptr_sum[ADDR_WIDTH-1:0];

            if (w_start) begin
                r_cmd_count <= '0;
                r_bursts    <= '0;
                r_overflow  <= 1'b0;
            end else begin
                if (w_cmd_hs)                r_cmd_count <= r_cmd_count + 32'd1;
                if (w_beat_hs && w_wr_last)  r_bursts    <= r_bursts + 32'd1;
                if (w_push_try && w_fifo_full) r_overflow <= 1'b1;
            end
        end
    end

    adc_capture_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk       (adc_clk),
        .rst       (adc_rst),
        .flush     (!calib_done),
        .push      (w_push_try),
        .push_data ({w_sample, r_half}),
        .pop       (w_beat_hs),
        .pop_data  (w_fifo_data),
        .count     (w_fifo_count),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    generate
        if (ADDR_WIDTH < 32) begin : g_addr_pad
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^r_cmd.addr[31:ADDR_WIDTH];
        end
    endgenerate

    assign adc_core_preset = r_preset;
    assign adc_enable_i0   = r_enable;
    assign adc_enable_q0   = r_enable;
    assign adc_r1_mode     = r_r1;
    assign cmd_valid       = r_cmd_valid;
    assign cmd_addr        = r_cmd.addr[ADDR_WIDTH-1:0];
    assign cmd_len         = r_cmd.len;
    assign wr_valid        = w_wr_valid;
    assign wr_last         = w_wr_last;
    assign wr_data         = w_wr_valid ? w_fifo_data : 64'd0;
    assign status_busy     = (r_state == CAPTURE) || (r_state == DRAIN);
    assign status_overflow = r_overflow;
    assign status_bursts   = r_bursts;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_capture_ctrl
// Description : Directed self-checking bench for adc_capture_ctrl (256-byte ring).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_capture_ctrl;
    import adc_capture_pkg::*;

    logic        adc_clk;
    logic        adc_rst;
    logic        calib_done;
    logic        cfg_start;
    logic        cfg_stop;
    logic [31:0] cfg_num_bursts;
    logic        adc_core_preset;
    logic        adc_enable_i0;
    logic        adc_enable_q0;
    logic        adc_r1_mode;
    logic        adc_valid;
    logic [15:0] adc_data_i0;
    logic [15:0] adc_data_q0;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [29:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [63:0] wr_data;
    logic        wr_last;
    logic        status_busy;
    logic        status_overflow;
    logic [31:0] status_bursts;

    int n_vec = 0;
    int n_err = 0;

    logic [29:0] addr_q[$];
    logic [7:0]  len_q[$];
    logic [63:0] beat_q[$];
    logic        last_q[$];

    adc_capture_ctrl #(
        .ADDR_WIDTH    (30),
        .BASE_ADDR     (0),
        .BUF_BYTES     (256),
        .BURST_BEATS   (16),
        .FIFO_DEPTH    (64),
        .PRESET_CYCLES (16)
    ) dut (
        .adc_clk         (adc_clk),
        .adc_rst         (adc_rst),
        .calib_done      (calib_done),
        .cfg_start       (cfg_start),
        .cfg_stop        (cfg_stop),
        .cfg_num_bursts  (cfg_num_bursts),
        .adc_core_preset (adc_core_preset),
        .adc_enable_i0   (adc_enable_i0),
        .adc_enable_q0   (adc_enable_q0),
        .adc_r1_mode     (adc_r1_mode),
        .adc_valid       (adc_valid),
        .adc_data_i0     (adc_data_i0),
        .adc_data_q0     (adc_data_q0),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .wr_data         (wr_data),
        .wr_last         (wr_last),
        .status_busy     (status_busy),
        .status_overflow (status_overflow),
        .status_bursts   (status_bursts)
    );

    initial adc_clk = 1'b0;
    always #5 adc_clk = ~adc_clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Handshake recorder: inputs change on negedge, so values 1 ns later hold
    // through the next posedge where the transfer takes place.
    always @(negedge adc_clk) begin
        #1;
        if (cmd_valid && cmd_ready) begin
            addr_q.push_back(cmd_addr);
            len_q.push_back(cmd_len);
        end
        if (wr_valid && wr_ready) begin
            beat_q.push_back(wr_data);
            last_q.push_back(wr_last);
        end
    end

    function automatic logic [31:0] samp(input int k);
        return {16'(k) ^ 16'h5A5A, 16'(k) + 16'h0100};
    endfunction

    function automatic logic [63:0] beat_exp(input int b);
        return {samp(2 * b + 1), samp(2 * b)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_samples(input int n);
        logic [31:0] s;
        for (int k = 0; k < n; k++) begin
            @(negedge adc_clk);
            s = samp(k);
            adc_valid   = 1'b1;
            adc_data_i0 = s[15:0];
            adc_data_q0 = s[31:16];
        end
        @(negedge adc_clk);
        adc_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge adc_clk);
        addr_q.delete(); len_q.delete(); beat_q.delete(); last_q.delete();
        cfg_start = 1'b1;
        @(negedge adc_clk);
        cfg_start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge adc_clk);
        cfg_stop = 1'b1;
        @(negedge adc_clk);
        cfg_stop = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int c;
        c = 0;
        while (status_busy && c < max_cycles) begin
            @(negedge adc_clk);
            c++;
        end
        check("idle within budget", status_busy, 0);
    endtask

    task automatic check_beats(input string tag, input int n);
        for (int b = 0; b < n; b++)
            check($sformatf("%s beat %0d", tag, b), beat_q[b], beat_exp(b));
    endtask

    function automatic logic [31:0] last_mask();
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < last_q.size() && i < 32; i++) m[i] = last_q[i];
        return m;
    endfunction

    initial begin
        int n;
        adc_rst = 1'b1; calib_done = 1'b0; cfg_start = 1'b0; cfg_stop = 1'b0;
        cfg_num_bursts = '0; adc_valid = 1'b0; adc_data_i0 = '0; adc_data_q0 = '0;
        cmd_ready = 1'b0; wr_ready = 1'b0;
        repeat (3) @(negedge adc_clk);
        adc_rst = 1'b0;
        @(negedge adc_clk);

        check("reset flags {preset,en_i0,en_q0,r1,cmd_v,wr_v,last,busy,ovf}",
              {adc_core_preset, adc_enable_i0, adc_enable_q0, adc_r1_mode, cmd_valid,
               wr_valid, wr_last, status_busy, status_overflow}, 9'b1_0000_0000);
        check("reset bursts", status_bursts, 0);
        check("reset wr_data", wr_data, 0);

        // Bring-up: preset falls PRESET_CYCLES+1 edges after calib_done is sampled
        repeat (5) @(negedge adc_clk);
        calib_done = 1'b1;
        @(posedge adc_clk);
        n = 0;
        do begin
            @(posedge adc_clk);
            n++;
            #1;
        end while (adc_core_preset && n < 40);
        check("preset fall edge count", n, 17);
        check("post-preset {preset,en_i0,en_q0,r1}",
              {adc_core_preset, adc_enable_i0, adc_enable_q0, adc_r1_mode}, 4'b0111);

        // Two full bursts then automatic return to ARMED
        cfg_num_bursts = 32'd2; cmd_ready = 1'b1; wr_ready = 1'b1;
        pulse_start();
        check("t2 busy after start", status_busy, 1);
        send_samples(64);
        wait_idle(200);
        check("t2 cmd count", addr_q.size(), 2);
        check("t2 addr0", addr_q[0], 30'h0);
        check("t2 addr1", addr_q[1], 30'h80);
        check("t2 len0", len_q[0], 15);
        check("t2 len1", len_q[1], 15);
        check("t2 beat count", beat_q.size(), 32);
        check("t2 wr_last mask", last_mask(), 32'h8000_8000);
        check_beats("t2", 32);
        check("t2 bursts", status_bursts, 2);
        check("t2 overflow", status_overflow, 0);

        // Continuous capture, ring wraps every two bursts
        cfg_num_bursts = 32'd0;
        pulse_start();
        send_samples(160);
        pulse_stop();
        wait_idle(300);
        check("t3 cmd count", addr_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3 addr%0d", i), addr_q[i], (i % 2 == 1) ? 30'h80 : 30'h0);
            check($sformatf("t3 len%0d", i), len_q[i], 15);
        end
        check("t3 bursts", status_bursts, 5);

        // Short burst on stop; odd 11th sample is discarded
        pulse_start();
        send_samples(11);
        pulse_stop();
        wait_idle(100);
        check("short cmd count", addr_q.size(), 1);
        check("short addr restarts at base", addr_q[0], 30'h0);
        check("short len", len_q[0], 4);
        check("short beat count", beat_q.size(), 5);
        check("short wr_last mask", last_mask(), 32'h10);
        check_beats("short", 5);
        check("short bursts", status_bursts, 1);

        // Back-pressure: FIFO fills, overflow sets, retained beats stay ordered
        wr_ready = 1'b0;
        pulse_start();
        send_samples(140);
        check("ovf sticky set", status_overflow, 1);
        pulse_stop();
        @(negedge adc_clk);
        wr_ready = 1'b1;
        wait_idle(400);
        check("ovf beat count", beat_q.size(), 64);
        check_beats("ovf", 64);
        check("ovf cmd count", addr_q.size(), 4);
        check("ovf addr2 wrapped", addr_q[2], 30'h0);
        check("ovf addr3", addr_q[3], 30'h80);
        check("ovf bursts", status_bursts, 4);

        // Calibration lost mid-burst
        wr_ready = 1'b0;
        pulse_start();
        check("drop overflow cleared by start", status_overflow, 0);
        check("drop bursts cleared by start", status_bursts, 0);
        send_samples(40);
        @(negedge adc_clk);
        wr_ready = 1'b1;
        repeat (3) @(negedge adc_clk);
        check("drop mid-burst wr_valid", wr_valid, 1);
        calib_done = 1'b0;
        @(posedge adc_clk);
        #1;
        check("drop {preset,en_i0,en_q0,cmd_v,wr_v,busy}",
              {adc_core_preset, adc_enable_i0, adc_enable_q0, cmd_valid, wr_valid, status_busy},
              6'b10_0000);
        check("drop state", 64'(dut.r_state), 64'(RESET_WAIT));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
